spi_slave_rx_mode3: RTL and testbench

SPI slave receiver for mode 3 (CPOL=1, CPHA=1), MSB first. It is the receive end of the mode-3 master transmitter's link. The block synchronises the external CS_N, SCLK and MOSI lines into the `In_clk` domain and detects SCLK rising edges. It shifts one bit in per rising edge while CS_N is low and presents each completed word as a one-cycle valid strobe. It is used to loop back and check the master TX path, and as the front end of on-board slave peripherals.

---
 rtl/spi_slave_rx_mode3_if.sv | 32 +++
 rtl/spi_slave_rx_mode3.sv | 121 ++++++++++++
 tb/tb_spi_slave_rx_mode3.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_rx_mode3_if.sv
// SPI mode-3 slave receive bundle: serial pins in, received words and status out.
interface spi_slave_rx_mode3_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  In_spi_cs_n;
    logic                  In_spi_sclk;
    logic                  In_spi_mosi;
    logic [DATA_WIDTH-1:0] Out_rx_data;
    logic                  Out_rx_valid;
    logic                  Out_rx_busy;
    logic                  Out_rx_err;

    modport slave (
        input  In_spi_cs_n,
        input  In_spi_sclk,
        input  In_spi_mosi,
        output Out_rx_data,
        output Out_rx_valid,
        output Out_rx_busy,
        output Out_rx_err
    );

    modport master (
        output In_spi_cs_n,
        output In_spi_sclk,
        output In_spi_mosi,
        input  Out_rx_data,
        input  Out_rx_valid,
        input  Out_rx_busy,
        input  Out_rx_err
    );
endinterface

// File: rtl/spi_slave_rx_mode3.sv
// SPI mode-3 (CPOL=1, CPHA=1) MSB-first slave receiver. Pins are synchronised
// into In_clk, SCLK rises shift MOSI in, and each completed word is presented
// with a one-cycle valid strobe. A CS release mid-word gives a one-cycle error.
module spi_slave_rx_mode3 #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 In_clk,
    input  logic                 In_rst,
    spi_slave_rx_mode3_if.slave  spi
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic {IDLE, RECV} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync_p0, sclk_sync_p0, mosi_sync_p0;
    logic                   sclk_prev_p1;
    logic                   cs_s, sclk_s, mosi_s, sclk_rise;

    logic [CW-1:0]          bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0]  shift_reg, shift_nxt;
    logic [DATA_WIDTH-1:0]  rx_data, rx_data_nxt;
    logic                   rx_valid, rx_valid_nxt;
    logic                   rx_err, rx_err_nxt;
    logic                   rx_busy, rx_busy_nxt;

    // Synchroniser chains plus one SCLK history flop; reset levels match the idle bus so no false rise appears
    always_ff @(posedge In_clk) begin
        if (In_rst) begin
            cs_sync_p0   <= '1;
            sclk_sync_p0 <= '1;
            mosi_sync_p0 <= '0;
            sclk_prev_p1 <= 1'b1;
        end else begin
            cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], spi.In_spi_cs_n};
            sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], spi.In_spi_sclk};
            mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], spi.In_spi_mosi};
            sclk_prev_p1 <= sclk_sync_p0[SYNC_STAGES-1];
        end
    end

    assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_p0[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_p1;

    // FSM state register
    always_ff @(posedge In_clk) begin
        if (In_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath decisions; CS release outranks a coincident SCLK rise
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift_reg;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        rx_err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_s) begin
                    state_nxt   = RECV;
                    bit_cnt_nxt = '0;
                    shift_nxt   = '0;
                end
            end
            RECV: begin
                if (cs_s) begin
                    state_nxt   = IDLE;
                    rx_err_nxt  = (bit_cnt != '0);
                    bit_cnt_nxt = '0;
                end else if (sclk_rise) begin
                    shift_nxt = {shift_reg[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        rx_data_nxt  = {shift_reg[DATA_WIDTH-2:0], mosi_s};
                        rx_valid_nxt = 1'b1;
                        bit_cnt_nxt  = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                bit_cnt_nxt = '0;
            end
        endcase
        rx_busy_nxt = (state_nxt == RECV);
    end

    // Registered counter, shifter and outputs; reset drops any frame in progress silently
    always_ff @(posedge In_clk) begin
        if (In_rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            rx_err    <= rx_err_nxt;
            rx_busy   <= rx_busy_nxt;
        end
    end

    assign spi.Out_rx_data  = rx_data;
    assign spi.Out_rx_valid = rx_valid;
    assign spi.Out_rx_busy  = rx_busy;
    assign spi.Out_rx_err   = rx_err;
endmodule

// File: tb/tb_spi_slave_rx_mode3.sv
// Bench for spi_slave_rx_mode3: directed and random mode-3 frames, expected
// words/aborts queued by a frame-level model, checked by a decoupled monitor.
module tb_spi_slave_rx_mode3;
    localparam int DW = 8;

    typedef struct {
        bit            is_err;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];
    logic [DW-1:0] last_data;

    spi_slave_rx_mode3_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave_rx_mode3 #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .In_clk (clk),
        .In_rst (rst),
        .spi    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every valid or err strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (bus.Out_rx_valid || bus.Out_rx_err) begin
            n_checks++;
            if (bus.Out_rx_valid && bus.Out_rx_err) begin
                n_errors++;
                $display("FAIL strobe_excl: valid=1 err=1, expected at most one at %0t", $time);
            end else if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_strobe: valid=%0b err=%0b data=0x%0h, expected none at %0t",
                         bus.Out_rx_valid, bus.Out_rx_err, bus.Out_rx_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.Out_rx_valid) begin
                    if (e.is_err || bus.Out_rx_data !== e.data) begin
                        n_errors++;
                        $display("FAIL rx_word: got valid data=0x%0h, expected %s 0x%0h at %0t",
                                 bus.Out_rx_data, e.is_err ? "err" : "valid", e.data, $time);
                    end
                    last_data = e.data;
                end else begin
                    if (!e.is_err || bus.Out_rx_data !== last_data) begin
                        n_errors++;
                        $display("FAIL rx_abort: got err data=0x%0h, expected %s held 0x%0h at %0t",
                                 bus.Out_rx_data, e.is_err ? "err" : "valid", last_data, $time);
                    end
                end
            end
        end
    end

    // Reference model at frame level: whole words become data events, a leftover tail becomes one abort
    task automatic model_frame(input bit bits[$]);
        int   nw;
        exp_t e;
        nw = bits.size() / DW;
        for (int w = 0; w < nw; w++) begin
            logic [DW-1:0] v;
            v = '0;
            for (int b = 0; b < DW; b++) v = {v[DW-2:0], bits[w*DW+b]};
            e.is_err = 1'b0;
            e.data   = v;
            exp_q.push_back(e);
        end
        if (bits.size() % DW != 0) begin
            e.is_err = 1'b1;
            e.data   = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic add_word(inout bit bits[$], input logic [DW-1:0] w);
        for (int b = DW - 1; b >= 0; b--) bits.push_back(w[b]);
    endtask

    task automatic drive_bits(input bit bits[$], input int h);
        for (int i = 0; i < bits.size(); i++) begin
            bus.In_spi_sclk = 1'b0;
            bus.In_spi_mosi = bits[i];
            repeat (h) @(negedge clk);
            bus.In_spi_sclk = 1'b1;
            repeat (h) @(negedge clk);
            if (i == 0) chk("busy_in_frame", {31'd0, bus.Out_rx_busy}, 32'd1);
        end
    endtask

    // One CS assertion carrying the given bits at half-period h In_clk cycles
    task automatic frame(input bit bits[$], input int h);
        model_frame(bits);
        bus.In_spi_cs_n = 1'b0;
        repeat (h) @(negedge clk);
        drive_bits(bits, h);
        repeat (h) @(negedge clk);
        bus.In_spi_cs_n = 1'b1;
        repeat (2 * h + 6) @(negedge clk);
        chk("busy_after_frame", {31'd0, bus.Out_rx_busy}, 32'd0);
    endtask

    initial begin
        bit q[$];
        int busy_hi;
        n_checks  = 0;
        n_errors  = 0;
        last_data = '0;
        rst = 1'b1;
        bus.In_spi_cs_n = 1'b1;
        bus.In_spi_sclk = 1'b1;
        bus.In_spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_data",  {24'd0, bus.Out_rx_data}, 32'd0);
        chk("reset_valid", {31'd0, bus.Out_rx_valid}, 32'd0);
        chk("reset_busy",  {31'd0, bus.Out_rx_busy}, 32'd0);
        chk("reset_err",   {31'd0, bus.Out_rx_err}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single word at SCLK = In_clk/100
        q.delete(); add_word(q, 8'hA5); frame(q, 50);
        chk("single_data_held", {24'd0, bus.Out_rx_data}, 32'hA5);

        // Back-to-back words in one CS assertion
        q.delete(); add_word(q, 8'h00); add_word(q, 8'hFF); add_word(q, 8'h5A); frame(q, 6);

        // Abort after 3 bits, then a clean frame
        q.delete(); for (int b = 0; b < 3; b++) q.push_back(b == 0 ? 1'b1 : 1'b1);
        frame(q, 5);
        chk("abort_data_held", {24'd0, bus.Out_rx_data}, 32'h5A);
        q.delete(); add_word(q, 8'h3C); frame(q, 5);

        // SCLK activity with CS high must be ignored
        busy_hi = 0;
        for (int i = 0; i < 16; i++) begin
            bus.In_spi_mosi = 1'($urandom);
            bus.In_spi_sclk = ~bus.In_spi_sclk;
            repeat (4) begin
                @(negedge clk);
                if (bus.Out_rx_busy) busy_hi++;
            end
        end
        bus.In_spi_sclk = 1'b1;
        repeat (8) @(negedge clk);
        chk("cs_idle_busy_cycles", busy_hi, 0);

        // Reset in the middle of a word: frame lost, no strobe
        q.delete(); for (int b = 0; b < 5; b++) q.push_back(1'b1);
        bus.In_spi_cs_n = 1'b0;
        repeat (5) @(negedge clk);
        drive_bits(q, 5);
        rst = 1'b1;
        @(negedge clk);
        last_data = '0;
        chk("midrst_data",  {24'd0, bus.Out_rx_data}, 32'd0);
        chk("midrst_valid", {31'd0, bus.Out_rx_valid}, 32'd0);
        chk("midrst_busy",  {31'd0, bus.Out_rx_busy}, 32'd0);
        chk("midrst_err",   {31'd0, bus.Out_rx_err}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.In_spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
        q.delete(); add_word(q, 8'h81); frame(q, 5);
        chk("after_rst_data", {24'd0, bus.Out_rx_data}, 32'h81);

        // Loopback-style incrementing words, 50 MHz / 500 kHz and minimum ratio
        for (int w = 0; w < 16; w++) begin
            q.delete(); add_word(q, 8'(w)); frame(q, 50);
        end
        for (int w = 0; w < 16; w++) begin
            q.delete(); add_word(q, 8'(w)); frame(q, 4);
        end

        // Random frames: whole words plus an optional partial tail
        for (int f = 0; f < 20; f++) begin
            int nw, tail;
            nw   = $urandom_range(0, 3);
            tail = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DW - 1) : 0;
            q.delete();
            for (int w = 0; w < nw; w++) add_word(q, 8'($urandom));
            for (int b = 0; b < tail; b++) q.push_back(1'($urandom));
            frame(q, $urandom_range(4, 12));
        end

        // Drain: every expected event must have been seen within a bounded wait
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("pending_events", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
